// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: parametrised raster timing and test-pattern generator for a parallel video transmitter
module video_timing_pattern_gen #(
  parameter int H_RES = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_RES = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [1:0]    mode,
  input  logic [23:0]   colour,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start
);
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_RES + H_FP;
  localparam int VS_START = V_RES + V_FP;
  localparam int BW = H_RES / 8;
  logic [CW-1:0] h_cnt, v_cnt, bar_px;
  logic [7:0] frame_cnt;
  logic [3:0] bar_idx;
  logic [1:0] mode_s;
  logic [23:0] colour_s, bars, pix;
  logic [31:0] hx, vx;
  logic h_last, v_last, act, in_hs, in_vs, white, bar_end;
  // decode the pixel at the current counter position
  always_comb begin
    hx = 32'(h_cnt);
    vx = 32'(v_cnt);
    h_last = h_cnt == CW'(H_TOTAL - 1);
    v_last = v_cnt == CW'(V_TOTAL - 1);
    act = (h_cnt < CW'(H_RES)) && (v_cnt < CW'(V_RES));
    in_hs = (h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_START + H_SYNC));
    in_vs = (v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_START + V_SYNC));
    bar_end = bar_px == CW'(BW - 1);
    white = (hx[4:0] == 5'd0) || (vx[4:0] == 5'd0) || (hx == H_RES - 1) || (vx == V_RES - 1);
    bars = bar_idx[3] ? 24'h0 : {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
    pix = !act ? 24'h0 :
          mode_s == 2'd0 ? colour_s :
          mode_s == 2'd1 ? bars :
          mode_s == 2'd2 ? {24{white}} : {hx[7:0], vx[7:0], frame_cnt};
  end
  // shadow the pattern controls so changes take effect only at a frame boundary
  always_ff @(posedge clk) begin
    if (reset || (run && h_last && v_last)) begin
      mode_s <= mode;
      colour_s <= colour;
    end
  end
  // raster counters, bar tracker and registered outputs one cycle behind the counters
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
      frame_cnt <= '0;
      bar_px <= '0;
      bar_idx <= '0;
      de <= 1'b0;
      hs <= ~HS_POL;
      vs <= ~VS_POL;
      {r, g, b} <= 24'h0;
      x <= '0;
      y <= '0;
      frame_start <= 1'b0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      v_cnt <= h_last ? (v_last ? '0 : v_cnt + 1'b1) : v_cnt;
      frame_cnt <= frame_cnt + 8'(h_last && v_last);
      bar_px <= (h_last || bar_end) ? '0 : bar_px + 1'b1;
      bar_idx <= h_last ? 4'd0 : (bar_end && !bar_idx[3]) ? bar_idx + 4'd1 : bar_idx;
      de <= act;
      hs <= in_hs ? HS_POL : ~HS_POL;
      vs <= in_vs ? VS_POL : ~VS_POL;
      {r, g, b} <= pix;
      x <= h_cnt;
      y <= v_cnt;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb_video_timing_pattern_gen: cycle-keyed scoreboard bench for video_timing_pattern_gen
module tb_video_timing_pattern_gen;
  localparam int FA = 800 * 26;
  localparam int FB = 17 * 9;
  typedef struct { int cyc; int f; logic [31:0] v; string n; } exp_t;
  logic clk = 1'b0;
  logic reset_a, run_a, reset_b, run_b;
  logic [1:0] mode_a, mode_b;
  logic [23:0] colour_a, colour_b;
  logic de_a, hs_a, vs_a, fs_a, de_b, hs_b, vs_b, fs_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [11:0] x_a, y_a, x_b, y_b;
  int edges = 0;
  int checks = 0;
  int errors = 0;
  int e0a, e0b, stop_b, e1b, rst_e, e2b;
  logic done_a = 1'b0;
  logic done_b = 1'b0;
  exp_t q[$];

  video_timing_pattern_gen #(.V_RES(20), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_a (
    .clk(clk), .reset(reset_a), .run(run_a), .mode(mode_a), .colour(colour_a),
    .de(de_a), .hs(hs_a), .vs(vs_a), .r(r_a), .g(g_a), .b(b_a),
    .x(x_a), .y(y_a), .frame_start(fs_a));

  video_timing_pattern_gen #(.H_RES(10), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_RES(6), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)) dut_b (
    .clk(clk), .reset(reset_b), .run(run_b), .mode(mode_b), .colour(colour_b),
    .de(de_b), .hs(hs_b), .vs(vs_b), .r(r_b), .g(g_b), .b(b_b),
    .x(x_b), .y(y_b), .frame_start(fs_b));

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic logic [31:0] get(int f);
    case (f)
      0: return 32'(de_a);
      1: return 32'(hs_a);
      2: return 32'(vs_a);
      3: return 32'(fs_a);
      4: return {8'h0, r_a, g_a, b_a};
      5: return 32'(x_a);
      6: return 32'(y_a);
      7: return 32'(de_b);
      8: return 32'(hs_b);
      9: return 32'(vs_b);
      10: return 32'(fs_b);
      11: return {8'h0, r_b, g_b, b_b};
      12: return 32'(x_b);
      default: return 32'(y_b);
    endcase
  endfunction

  function automatic int ca(int h, int v, int fr);
    return e0a + fr * FA + v * 800 + h;
  endfunction

  function automatic int cb(int h, int v, int fr);
    return e0b + fr * FB + v * 17 + h;
  endfunction

  task automatic push(string n, int f, int c, logic [31:0] v);
    q.push_back('{c, f, v, n});
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(int c);
    while (edges < c) tick(1);
  endtask

  // monitor: compare every expectation keyed to the current output cycle
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == edges) begin
        logic [31:0] act;
        act = get(q[i].f);
        checks++;
        if (act !== q[i].v) begin
          errors++;
          $display("FAIL %s at edge %0d: got %h, expected %h", q[i].n, edges, act, q[i].v);
        end
        q.delete(i);
      end
    end
  end

  // default line timing, frame timing, solid fill, bars, grid and frame-synchronous switching
  initial begin
    reset_a = 1'b1; run_a = 1'b1; mode_a = 2'd0; colour_a = 24'h123456;
    tick(5);
    push("a_rst_de", 0, edges, 0);
    push("a_rst_hs", 1, edges, 1);
    push("a_rst_vs", 2, edges, 1);
    push("a_rst_rgb", 4, edges, 0);
    push("a_rst_fs", 3, edges, 0);
    reset_a = 1'b0;
    e0a = edges + 1;
    push("a_first_fs", 3, ca(0, 0, 0), 1);
    push("a_first_de", 0, ca(0, 0, 0), 1);
    push("a_first_x", 5, ca(0, 0, 0), 0);
    push("a_first_y", 6, ca(0, 0, 0), 0);
    push("a_first_rgb", 4, ca(0, 0, 0), 32'h123456);
    for (int h = 0; h < 800; h++) begin
      push("a_line_de", 0, ca(h, 1, 0), 32'(h < 640));
      push("a_line_hs", 1, ca(h, 1, 0), 32'(!(h >= 656 && h < 752)));
    end
    for (int v = 0; v < 26; v++) begin
      push("a_vs_sol", 2, ca(0, v, 0), 32'(!(v == 22 || v == 23)));
      push("a_vs_eol", 2, ca(799, v, 0), 32'(!(v == 22 || v == 23)));
    end
    push("a_fs_before", 3, ca(799, 25, 0), 0);
    push("a_fs_period", 3, ca(0, 0, 1), 1);
    push("a_fs_after", 3, ca(1, 0, 1), 0);
    push("a_fs_period2", 3, ca(0, 0, 2), 1);
    push("a_xy_x", 5, ca(123, 7, 0), 123);
    push("a_xy_y", 6, ca(123, 7, 0), 7);
    push("a_solid_mid", 4, ca(100, 10, 0), 32'h123456);
    push("a_solid_end", 4, ca(639, 19, 0), 32'h123456);
    push("a_hblank", 4, ca(700, 3, 0), 0);
    push("a_vblank", 4, ca(5, 22, 0), 0);
    push("a_bar0", 4, ca(0, 0, 1), 32'hFFFFFF);
    push("a_bar0_end", 4, ca(79, 0, 1), 32'hFFFFFF);
    push("a_bar1", 4, ca(80, 0, 1), 32'hFFFF00);
    push("a_bar2", 4, ca(160, 3, 1), 32'h00FFFF);
    push("a_bar3", 4, ca(240, 3, 1), 32'h00FF00);
    push("a_bar4", 4, ca(320, 3, 1), 32'hFF00FF);
    push("a_bar5", 4, ca(400, 3, 1), 32'hFF0000);
    push("a_bar6", 4, ca(480, 3, 1), 32'h0000FF);
    push("a_bar7", 4, ca(560, 3, 1), 32'h000000);
    push("a_bar_last", 4, ca(639, 3, 1), 32'h000000);
    push("a_bar_blank", 4, ca(640, 3, 1), 0);
    push("a_grid_00", 4, ca(0, 0, 2), 32'hFFFFFF);
    push("a_grid_55", 4, ca(5, 5, 2), 0);
    push("a_grid_x32", 4, ca(32, 5, 2), 32'hFFFFFF);
    push("a_grid_ylast", 4, ca(5, 19, 2), 32'hFFFFFF);
    push("a_grid_xlast", 4, ca(639, 5, 2), 32'hFFFFFF);
    push("a_grid_638", 4, ca(638, 5, 2), 0);
    push("a_grid_51", 4, ca(5, 1, 2), 0);
    tick_to(ca(5, 10, 0));
    mode_a = 2'd1;
    colour_a = 24'hABCDEF;
    tick_to(ca(798, 25, 1));
    mode_a = 2'd2;
    tick(1);
    mode_a = 2'd3;
    tick_to(ca(6, 19, 2));
    done_a = 1'b1;
  end

  // small raster: polarity, gradient, frame counter wrap, run drop and mid-line reset
  initial begin
    reset_b = 1'b1; run_b = 1'b1; mode_b = 2'd3; colour_b = 24'h0;
    tick(5);
    push("b_rst_hs", 8, edges, 0);
    push("b_rst_vs", 9, edges, 0);
    push("b_rst_de", 7, edges, 0);
    push("b_rst_rgb", 11, edges, 0);
    reset_b = 1'b0;
    e0b = edges + 1;
    push("b_first_fs", 10, cb(0, 0, 0), 1);
    push("b_first_de", 7, cb(0, 0, 0), 1);
    for (int h = 0; h < 17; h++) push("b_hs", 8, cb(h, 0, 0), 32'(h >= 12 && h <= 14));
    for (int v = 0; v < 9; v++) begin
      push("b_vs", 9, cb(0, v, 0), 32'(v == 7));
      push("b_de_last", 7, cb(9, v, 0), 32'(v < 6));
      push("b_de_fp", 7, cb(10, v, 0), 0);
    end
    push("b_grad0", 11, cb(3, 4, 0), {8'h0, 8'd3, 8'd4, 8'd0});
    push("b_grad1", 11, cb(3, 4, 1), {8'h0, 8'd3, 8'd4, 8'd1});
    push("b_blank", 11, cb(11, 0, 0), 0);
    push("b_frame2", 11, cb(0, 0, 2), 32'h000002);
    push("b_frame255", 11, cb(9, 5, 255), {8'h0, 8'd9, 8'd5, 8'd255});
    push("b_wrap", 11, cb(0, 0, 256), 0);
    push("b_wrap_x1", 11, cb(1, 0, 256), {8'h0, 8'd1, 8'd0, 8'd0});
    push("b_fs_period", 10, cb(0, 0, 1), 1);
    push("b_fs_before", 10, cb(16, 8, 0), 0);
    tick_to(cb(5, 3, 257));
    run_b = 1'b0;
    stop_b = edges + 1;
    push("b_stop_de", 7, stop_b, 0);
    push("b_stop_hs", 8, stop_b, 0);
    push("b_stop_vs", 9, stop_b, 0);
    push("b_stop_rgb", 11, stop_b, 0);
    push("b_stop_x", 12, stop_b, 0);
    push("b_stop_y", 13, stop_b, 0);
    push("b_stop_fs", 10, stop_b, 0);
    push("b_stop_de_late", 7, stop_b + 49, 0);
    push("b_stop_x_late", 12, stop_b + 49, 0);
    tick_to(stop_b + 49);
    run_b = 1'b1;
    e1b = edges + 1;
    push("b_run_fs", 10, e1b, 1);
    push("b_run_de", 7, e1b, 1);
    push("b_run_x", 12, e1b, 0);
    push("b_run_y", 13, e1b, 0);
    push("b_run_grad", 11, e1b + 3 * 17 + 5, {8'h0, 8'd5, 8'd3, 8'd0});
    push("b_run_fs2", 10, e1b + FB, 1);
    push("b_run_frame1", 11, e1b + FB + 2, {8'h0, 8'd2, 8'd0, 8'd1});
    tick_to(e1b + FB + 4);
    reset_b = 1'b1;
    rst_e = edges + 1;
    push("b_mid_rst_de", 7, rst_e, 0);
    push("b_mid_rst_x", 12, rst_e, 0);
    push("b_mid_rst_rgb", 11, rst_e, 0);
    push("b_mid_rst_fs", 10, rst_e, 0);
    tick_to(rst_e);
    reset_b = 1'b0;
    e2b = edges + 1;
    push("b_rel_fs", 10, e2b, 1);
    push("b_rel_de", 7, e2b, 1);
    push("b_rel_x", 12, e2b, 0);
    push("b_rel_y", 13, e2b, 0);
    push("b_rel_l1_x", 12, e2b + 19, 2);
    push("b_rel_l1_y", 13, e2b + 19, 1);
    tick_to(e2b + 20);
    done_b = 1'b1;
  end

  // end of run: bounded wait, flag unchecked expectations, summary
  initial begin
    for (int i = 0; i < 90000 && !(done_a && done_b); i++) @(posedge clk);
    if (!(done_a && done_b)) begin
      checks++;
      errors++;
      $display("FAIL timeout: got done_a=%0b done_b=%0b, expected both 1", done_a, done_b);
    end
    repeat (2) @(negedge clk);
    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s never observed: edge %0d, expected %h", q[i].n, q[i].cyc, q[i].v);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
